// File: rtl/flip_flop_if.sv
// Data bus for the flip_flop register stage: d flows master -> slave, q flows back.
interface flip_flop_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input  q);
  modport slave  (input  d, output q);
endinterface

// File: rtl/flip_flop.sv
// Parameterised D register / short delay line with asynchronous active-low reset.
// q is taken straight from the last stage register.
module flip_flop #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       STAGES    = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  flip_flop_if.slave bus
);

  localparam int unsigned LAST = STAGES - 1;

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > 16) begin : g_cfg_err
      $fatal(1, "flip_flop: illegal configuration WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end
  endgenerate

  logic [WIDTH-1:0] stage [STAGES];

  // Every stage is cleared on reset so no in-flight data survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= bus.d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign bus.q = stage[LAST];

endmodule

// File: tb/tb_flip_flop.sv
// Directed bench for flip_flop: default 1-bit single stage and an 8-bit, 3-stage,
// RESET_VAL=8'hA5 delay-line configuration.
module tb_flip_flop;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   vectors;
  int   errors;

  flip_flop_if #(.WIDTH(1)) bus_a ();
  flip_flop_if #(.WIDTH(8)) bus_b ();

  flip_flop dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  flip_flop #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'hA5)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    bus_a.d = 1'b0;
    bus_b.d = 8'h00;

    // Power-up reset, default config
    #2;
    check("a_por_async", 8'(bus_a.q), 8'h00);
    tick();
    check("a_por_held", 8'(bus_a.q), 8'h00);
    reset_a = 1'b1;
    bus_a.d = 1'b0;
    tick();
    check("a_release_zero", 8'(bus_a.q), 8'h00);

    // Capture
    bus_a.d = 1'b1;
    tick();
    check("a_capture_1", 8'(bus_a.q), 8'h01);
    bus_a.d = 1'b0;
    tick();
    check("a_capture_0", 8'(bus_a.q), 8'h00);
    bus_a.d = 1'b1;
    tick();
    check("a_capture_1b", 8'(bus_a.q), 8'h01);

    // Async reset between edges
    reset_a = 1'b0;
    #1;
    check("a_async_mid", 8'(bus_a.q), 8'h00);

    // Reset dominance with d=1
    bus_a.d = 1'b1;
    tick();
    check("a_dom_edge1", 8'(bus_a.q), 8'h00);
    tick();
    check("a_dom_edge2", 8'(bus_a.q), 8'h00);
    reset_a = 1'b1;
    #1;
    check("a_release_nochange", 8'(bus_a.q), 8'h00);
    tick();
    check("a_post_release_1", 8'(bus_a.q), 8'h01);
    bus_a.d = 1'b0;
    tick();
    check("a_post_release_0", 8'(bus_a.q), 8'h00);
    #3;
    check("a_no_glitch", 8'(bus_a.q), 8'h00);

    // Reset coincident with a clock edge
    bus_a.d = 1'b1;
    tick();
    check("a_pre_coincident", 8'(bus_a.q), 8'h01);
    @(posedge clk);
    reset_a = 1'b0;
    #1;
    check("a_coincident", 8'(bus_a.q), 8'h00);
    reset_a = 1'b1;

    // 8-bit, 3-stage configuration
    check("b_reset_val", bus_b.q, 8'hA5);
    tick();
    check("b_reset_held", bus_b.q, 8'hA5);
    reset_b = 1'b1;
    bus_b.d = 8'h3C;
    tick();
    check("b_lat_edge1", bus_b.q, 8'hA5);
    bus_b.d = 8'h00;
    tick();
    check("b_lat_edge2", bus_b.q, 8'hA5);
    tick();
    check("b_lat_edge3", bus_b.q, 8'h3C);
    tick();
    check("b_lat_edge4", bus_b.q, 8'h00);

    // Reset mid-pipe clears every stage
    bus_b.d = 8'h5A;
    tick();
    bus_b.d = 8'hC3;
    tick();
    reset_b = 1'b0;
    #1;
    check("b_mid_reset", bus_b.q, 8'hA5);
    reset_b = 1'b1;
    bus_b.d = 8'h77;
    tick();
    check("b_flush_edge1", bus_b.q, 8'hA5);
    tick();
    check("b_flush_edge2", bus_b.q, 8'hA5);
    tick();
    check("b_flush_edge3", bus_b.q, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
